// File: rtl/coolgirl_pkg.sv
// Shared constants for the COOLGIRL configuration register block: register indices,
// R4 bit layout, reset values and the reset-vector detector state type.
package coolgirl_pkg;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // R4 field positions; sram_page occupies two bits starting at R4_SRAM_PAGE
    localparam int unsigned R4_SRAM_PAGE   = 0;
    localparam int unsigned R4_SRAM_EN     = 2;
    localparam int unsigned R4_ROM_6000    = 3;
    localparam int unsigned R4_PRG_WE      = 4;
    localparam int unsigned R4_CHR_WE      = 5;
    localparam int unsigned R4_FOUR_SCREEN = 6;
    localparam int unsigned R7_LOCKOUT     = 7;

    localparam logic [7:0] R0_RST   = 8'h00;
    localparam logic [4:0] R1_RST   = 5'h00;
    localparam logic [6:0] R2_RST   = 7'h00;
    localparam logic [4:0] R3_RST   = 5'h00;
    localparam logic [6:0] R4_RST   = 7'h00;
    localparam logic [7:0] R5_RST   = 8'h00;
    localparam logic       R6_RST   = 1'b0;
    localparam logic       LOCK_RST = 1'b0;

    localparam logic [2:0]  WIN_5000 = 3'b101;
    localparam logic [14:0] VEC_LO   = 15'h7FFC;
    localparam logic [14:0] VEC_HI   = 15'h7FFD;

    typedef enum logic {
        IDLE,
        GOT_LO
    } vec_state_e;

endpackage

// File: rtl/coolgirl_cfg_regs_if.sv
// CPU bus as seen by the configuration registers; the bench or CPU side is the master.
interface coolgirl_cfg_regs_if;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;

    modport master (output romsel, output cpu_rw_in, output cpu_addr_in, output cpu_data_in);
    modport slave  (input romsel, input cpu_rw_in, input cpu_addr_in, input cpu_data_in);
endinterface

// File: rtl/coolgirl_vector_detect.sv
// Watches for the CPU fetching the reset vector ($FFFC then $FFFD) and raises a
// single-cycle restore pulse during the $FFFD read.
module coolgirl_vector_detect
    import coolgirl_pkg::*;
(
    input  logic        m2,
    input  logic        reset,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    output logic        restore
);

    vec_state_e state_q;
    logic       rd_lo;
    logic       rd_hi;

    assign rd_lo = cpu_rw_in && !romsel && (cpu_addr_in == VEC_LO);
    assign rd_hi = cpu_rw_in && !romsel && (cpu_addr_in == VEC_HI);

    always_ff @(posedge m2) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:   state_q <= rd_lo ? GOT_LO : IDLE;
                GOT_LO: state_q <= rd_lo ? GOT_LO : IDLE;
            endcase
        end
    end

    // Decoded from the live bus so the restore lands on the edge that samples $FFFD.
    assign restore = (state_q == GOT_LO) && rd_hi && !reset;

endmodule

// File: rtl/coolgirl_cfg_regs.sv
// COOLGIRL mapper configuration registers at $5000-$5FFF (8 mirrored registers),
// with write lockout and restore-to-menu on a CPU reset-vector fetch.
module coolgirl_cfg_regs
    import coolgirl_pkg::*;
#(
    parameter int unsigned USE_FOUR_SCREEN = 1,
    parameter int unsigned MAPPER_BITS     = 5
) (
    input  logic                   m2,
    input  logic                   reset,
    coolgirl_cfg_regs_if.slave     bus,
    output logic [12:0]            cpu_base,
    output logic [6:0]             prg_mask,
    output logic [4:0]             chr_mask,
    output logic [1:0]             sram_page,
    output logic                   sram_enabled,
    output logic                   map_rom_on_6000,
    output logic                   prg_write_enabled,
    output logic                   chr_write_enabled,
    output logic                   four_screen,
    output logic                   menu_on_reset,
    output logic                   lockout,
    output logic [MAPPER_BITS-1:0] mapper_sel,
    output logic                   mapper_reset
);

    logic [7:0]             r0_q;
    logic [4:0]             r1_q;
    logic [6:0]             r2_q;
    logic [4:0]             r3_q;
    logic [6:0]             r4_q;
    logic [MAPPER_BITS-1:0] r5_q;
    logic                   r6_q;
    logic                   lock_q;
    logic                   mres_q;

    logic       wr;
    logic [2:0] idx;
    logic       restore_req;
    logic       restore;
    logic       unused_addr;

    coolgirl_vector_detect u_vector_detect (
        .m2          (m2),
        .reset       (reset),
        .romsel      (bus.romsel),
        .cpu_rw_in   (bus.cpu_rw_in),
        .cpu_addr_in (bus.cpu_addr_in),
        .restore     (restore_req)
    );

    assign wr = bus.romsel && !bus.cpu_rw_in && (bus.cpu_addr_in[14:12] == WIN_5000) && !lock_q;
    assign idx         = bus.cpu_addr_in[2:0];
    assign restore     = restore_req && r6_q;
    assign unused_addr = ^bus.cpu_addr_in[11:3];

    always_ff @(posedge m2) begin
        if (reset) begin
            r0_q   <= R0_RST;
            r1_q   <= R1_RST;
            r2_q   <= R2_RST;
            r3_q   <= R3_RST;
            r4_q   <= R4_RST;
            r5_q   <= R5_RST[MAPPER_BITS-1:0];
            r6_q   <= R6_RST;
            lock_q <= LOCK_RST;
            mres_q <= 1'b0;
        end else if (restore) begin
            // Back to the menu: everything but menu_on_reset, and the lockout is lifted.
            r0_q   <= R0_RST;
            r1_q   <= R1_RST;
            r2_q   <= R2_RST;
            r3_q   <= R3_RST;
            r4_q   <= R4_RST;
            r5_q   <= R5_RST[MAPPER_BITS-1:0];
            lock_q <= LOCK_RST;
            mres_q <= 1'b1;
        end else begin
            mres_q <= 1'b0;
            if (wr) begin
                case (idx)
                    R0: r0_q <= bus.cpu_data_in;
                    R1: r1_q <= bus.cpu_data_in[4:0];
                    R2: r2_q <= bus.cpu_data_in[6:0];
                    R3: r3_q <= bus.cpu_data_in[4:0];
                    R4: r4_q <= bus.cpu_data_in[6:0];
                    R5: begin
                        r5_q   <= bus.cpu_data_in[MAPPER_BITS-1:0];
                        mres_q <= 1'b1;
                    end
                    R6: r6_q <= bus.cpu_data_in[0];
                    R7: if (bus.cpu_data_in[R7_LOCKOUT]) lock_q <= 1'b1;
                endcase
            end
        end
    end

    assign cpu_base          = {r0_q, r1_q};
    assign prg_mask          = r2_q;
    assign chr_mask          = r3_q;
    assign sram_page         = r4_q[R4_SRAM_PAGE +: 2];
    assign sram_enabled      = r4_q[R4_SRAM_EN];
    assign map_rom_on_6000   = r4_q[R4_ROM_6000];
    assign prg_write_enabled = r4_q[R4_PRG_WE];
    assign chr_write_enabled = r4_q[R4_CHR_WE];
    assign four_screen       = (USE_FOUR_SCREEN != 0) ? r4_q[R4_FOUR_SCREEN] : 1'b0;
    assign menu_on_reset     = r6_q;
    assign lockout           = lock_q;
    assign mapper_sel        = r5_q;
    assign mapper_reset      = mres_q;

endmodule

// File: tb/tb_coolgirl_cfg_regs.sv
// Directed table-driven bench for coolgirl_cfg_regs: one row per m2 cycle, checked after the edge.
module tb_coolgirl_cfg_regs;

    logic m2;
    logic reset;

    coolgirl_cfg_regs_if bus ();

    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic [4:0]  chr_mask;
    logic [1:0]  sram_page;
    logic        sram_enabled, map_rom_on_6000, prg_write_enabled, chr_write_enabled;
    logic        four_screen, menu_on_reset, lockout, mapper_reset;
    logic [4:0]  mapper_sel;

    logic [12:0] nf_cpu_base;
    logic [6:0]  nf_prg_mask;
    logic [4:0]  nf_chr_mask;
    logic [1:0]  nf_sram_page;
    logic        nf_sram_enabled, nf_map_rom_on_6000, nf_prg_write_enabled, nf_chr_write_enabled;
    logic        nf_four_screen, nf_menu_on_reset, nf_lockout, nf_mapper_reset;
    logic [4:0]  nf_mapper_sel;

    coolgirl_cfg_regs #(.USE_FOUR_SCREEN(1), .MAPPER_BITS(5)) u_dut (
        .m2(m2), .reset(reset), .bus(bus),
        .cpu_base(cpu_base), .prg_mask(prg_mask), .chr_mask(chr_mask), .sram_page(sram_page),
        .sram_enabled(sram_enabled), .map_rom_on_6000(map_rom_on_6000),
        .prg_write_enabled(prg_write_enabled), .chr_write_enabled(chr_write_enabled),
        .four_screen(four_screen), .menu_on_reset(menu_on_reset), .lockout(lockout),
        .mapper_sel(mapper_sel), .mapper_reset(mapper_reset)
    );

    coolgirl_cfg_regs #(.USE_FOUR_SCREEN(0), .MAPPER_BITS(5)) u_nofour (
        .m2(m2), .reset(reset), .bus(bus),
        .cpu_base(nf_cpu_base), .prg_mask(nf_prg_mask), .chr_mask(nf_chr_mask),
        .sram_page(nf_sram_page), .sram_enabled(nf_sram_enabled),
        .map_rom_on_6000(nf_map_rom_on_6000), .prg_write_enabled(nf_prg_write_enabled),
        .chr_write_enabled(nf_chr_write_enabled), .four_screen(nf_four_screen),
        .menu_on_reset(nf_menu_on_reset), .lockout(nf_lockout),
        .mapper_sel(nf_mapper_sel), .mapper_reset(nf_mapper_reset)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    typedef struct {
        string       name;
        logic        rst;
        logic        rs;
        logic        rw;
        logic [14:0] addr;
        logic [7:0]  data;
        logic [12:0] base;
        logic [6:0]  prg;
        logic [4:0]  chr;
        logic [6:0]  r4;
        logic [4:0]  map;
        logic        mres;
        logic        menu;
        logic        lock;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input string n, input logic rst, input logic rs, input logic rw,
                       input logic [14:0] addr, input logic [7:0] data,
                       input logic [12:0] base, input logic [6:0] prg, input logic [4:0] chr,
                       input logic [6:0] r4, input logic [4:0] map,
                       input logic mres, input logic menu, input logic lock);
        vec_t v;
        v.name = n; v.rst = rst; v.rs = rs; v.rw = rw; v.addr = addr; v.data = data;
        v.base = base; v.prg = prg; v.chr = chr; v.r4 = r4; v.map = map;
        v.mres = mres; v.menu = menu; v.lock = lock;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic rs, input logic rw,
                         input logic [14:0] addr, input logic [7:0] data);
        @(negedge m2);
        reset           = rst;
        bus.romsel      = rs;
        bus.cpu_rw_in   = rw;
        bus.cpu_addr_in = addr;
        bus.cpu_data_in = data;
        @(posedge m2);
        #1;
    endtask

    task automatic check(input string n, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    logic [39:0] obs;
    logic [39:0] exp_v;
    int          pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        bus.romsel      = 1'b1;
        bus.cpu_rw_in   = 1'b1;
        bus.cpu_addr_in = 15'h0000;
        bus.cpu_data_in = 8'h00;

        //   name          rst rs rw addr      data   base     prg    chr    r4     map  mr mn lk
        add("reset",        1, 1, 1, 15'h0000, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r0_a5",      0, 1, 0, 15'h5000, 8'hA5, 13'h14A0, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r1_13",      0, 1, 0, 15'h5001, 8'h13, 13'h14B3, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r2_7f",      0, 1, 0, 15'h5002, 8'h7F, 13'h14B3, 7'h7F, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r3_e5",      0, 1, 0, 15'h5003, 8'hE5, 13'h14B3, 7'h7F, 5'h05, 7'h00, 5'h0, 0, 0, 0);
        add("w_r4_5e",      0, 1, 0, 15'h5004, 8'h5E, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h0, 0, 0, 0);
        add("w_r5_03_a",    0, 1, 0, 15'h5005, 8'h03, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 1, 0, 0);
        add("w_r5_03_b",    0, 1, 0, 15'h5005, 8'h03, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 1, 0, 0);
        add("idle_mres0",   0, 1, 1, 15'h0000, 8'h00, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 0, 0, 0);
        add("rd_r5",        0, 1, 1, 15'h5005, 8'h1F, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 0, 0, 0);
        add("w_romsel0",    0, 0, 0, 15'h5005, 8'h1F, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 0, 0, 0);
        add("w_4005",       0, 1, 0, 15'h4005, 8'h1F, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h3, 0, 0, 0);
        add("w_mirror_r5",  0, 1, 0, 15'h5FFD, 8'hE7, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 1, 0, 0);
        add("w_r7_00",      0, 1, 0, 15'h5007, 8'h00, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 0, 0);
        add("w_r6_ff",      0, 1, 0, 15'h5006, 8'hFF, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 0);
        add("w_r7_80",      0, 1, 0, 15'h5007, 8'h80, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 1);
        add("lock_r0",      0, 1, 0, 15'h5000, 8'hFF, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 1);
        add("lock_5abf",    0, 1, 0, 15'h5ABF, 8'h00, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 1);
        add("lock_r5",      0, 1, 0, 15'h5005, 8'h01, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 1);
        add("rd_fffc",      0, 0, 1, 15'h7FFC, 8'h00, 13'h14B3, 7'h7F, 5'h05, 7'h5E, 5'h7, 0, 1, 1);
        add("rd_fffd_rst",  0, 0, 1, 15'h7FFD, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 1, 1, 0);
        add("idle_post",    0, 1, 1, 15'h0000, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 1, 0);
        add("w_r0_ff",      0, 1, 0, 15'h5000, 8'hFF, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h0, 0, 1, 0);
        add("w_r5_02",      0, 1, 0, 15'h5005, 8'h02, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 1, 1, 0);
        add("rd_fffc_2",    0, 0, 1, 15'h7FFC, 8'h00, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 0, 1, 0);
        add("rd_8000",      0, 0, 1, 15'h0000, 8'h00, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 0, 1, 0);
        add("rd_fffd_none", 0, 0, 1, 15'h7FFD, 8'h00, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 0, 1, 0);
        add("rd_fffc_3",    0, 0, 1, 15'h7FFC, 8'h00, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 0, 1, 0);
        add("rd_fffc_4",    0, 0, 1, 15'h7FFC, 8'h00, 13'h1FE0, 7'h00, 5'h00, 7'h00, 5'h2, 0, 1, 0);
        add("rd_fffd_rst2", 0, 0, 1, 15'h7FFD, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 1, 1, 0);
        add("w_r6_00",      0, 1, 0, 15'h5006, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r1_01",      0, 1, 0, 15'h5001, 8'h01, 13'h0001, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("rd_fffc_5",    0, 0, 1, 15'h7FFC, 8'h00, 13'h0001, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("rd_fffd_nomn", 0, 0, 1, 15'h7FFD, 8'h00, 13'h0001, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r6_01",      0, 1, 0, 15'h5006, 8'h01, 13'h0001, 7'h00, 5'h00, 7'h00, 5'h0, 0, 1, 0);
        add("w_r0_11",      0, 1, 0, 15'h5000, 8'h11, 13'h0221, 7'h00, 5'h00, 7'h00, 5'h0, 0, 1, 0);
        add("rd_fffc_6",    0, 0, 1, 15'h7FFC, 8'h00, 13'h0221, 7'h00, 5'h00, 7'h00, 5'h0, 0, 1, 0);
        add("rst_in_gotlo", 1, 0, 1, 15'h7FFD, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("rd_fffd_post", 0, 0, 1, 15'h7FFD, 8'h00, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);
        add("w_r4_7f",      0, 1, 0, 15'h5004, 8'h7F, 13'h0000, 7'h00, 5'h00, 7'h7F, 5'h0, 0, 0, 0);
        add("rst_vs_write", 1, 1, 0, 15'h5000, 8'hFF, 13'h0000, 7'h00, 5'h00, 7'h00, 5'h0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rs, vecs[i].rw, vecs[i].addr, vecs[i].data);
            obs = {cpu_base, prg_mask, chr_mask,
                   four_screen, chr_write_enabled, prg_write_enabled, map_rom_on_6000,
                   sram_enabled, sram_page, mapper_sel, mapper_reset, menu_on_reset, lockout};
            exp_v = {vecs[i].base, vecs[i].prg, vecs[i].chr, vecs[i].r4, vecs[i].map,
                     vecs[i].mres, vecs[i].menu, vecs[i].lock};
            check(vecs[i].name, obs, exp_v);
        end

        // Four-screen disabled build keeps the rest of R4 but never drives four_screen.
        drive(1'b1, 1'b1, 1'b1, 15'h0000, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 15'h5004, 8'h5E);
        check("fs_enabled", {39'd0, four_screen}, 40'd1);
        check("fs_disabled", {39'd0, nf_four_screen}, 40'd0);
        check("fs_dis_page", {38'd0, nf_sram_page}, 40'd2);
        check("fs_dis_flags", {36'd0, nf_chr_write_enabled, nf_prg_write_enabled,
                               nf_map_rom_on_6000, nf_sram_enabled}, 40'h7);

        // Same R5 value written twice: each write pulses, so two high cycles in total.
        pulses = 0;
        drive(1'b0, 1'b1, 1'b0, 15'h5005, 8'h03);
        pulses += int'(mapper_reset);
        drive(1'b0, 1'b1, 1'b0, 15'h5005, 8'h03);
        pulses += int'(mapper_reset);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 15'h0000, 8'h00);
            pulses += int'(mapper_reset);
        end
        check("r5_twice_pulses", 40'(pulses), 40'd2);
        check("r5_twice_sel", {35'd0, mapper_sel}, 40'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
